// File: rtl/traffic_light_ctrl_param.sv
// traffic_light_ctrl_param: two-road traffic-light controller with prescaler, parametrised phase times and switch-selected modes
module traffic_light_ctrl_param #(
    parameter int CLK_DIV     = 4,
    parameter int T_GREEN     = 5,
    parameter int T_YELLOW    = 2,
    parameter int T_ALLRED    = 1,
    parameter int FLASH_TICKS = 1,
    parameter int TW          = 8,
    parameter int DW          = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sw,
    output logic       led4_r,
    output logic       led4_g,
    output logic       led4_b,
    output logic       led5_r,
    output logic       led5_g,
    output logic       led5_b,
    output logic [2:0] phase
);
    localparam logic [2:0] RR_A  = 3'd0;
    localparam logic [2:0] GR    = 3'd1;
    localparam logic [2:0] YR    = 3'd2;
    localparam logic [2:0] RR_B  = 3'd3;
    localparam logic [2:0] RG    = 3'd4;
    localparam logic [2:0] RY    = 3'd5;
    localparam logic [2:0] FLASH = 3'd6;
    localparam logic [TW-1:0] G_END = TW'(T_GREEN - 1);
    localparam logic [TW-1:0] Y_END = TW'(T_YELLOW - 1);
    localparam logic [TW-1:0] R_END = TW'(T_ALLRED - 1);
    localparam logic [TW-1:0] F_END = TW'(FLASH_TICKS - 1);
    localparam logic [DW-1:0] DIV_END = DW'(CLK_DIV - 1);
    logic [1:0]    sw_meta_q, sw_meta_d, mode_q, mode_d;
    logic [DW-1:0] div_q, div_d;
    logic [TW-1:0] timer_q, timer_d, t_end;
    logic [2:0]    state_q, state_d;
    logic          blink_q, blink_d;
    logic          tick, expire, stop, green, yellow, red, lit;
    always_comb begin
        sw_meta_d = sw;
        mode_d    = sw_meta_q;
        tick      = div_q == DIV_END;
        div_d     = tick ? '0 : div_q + DW'(1);
        green     = state_q == GR || state_q == RG;
        yellow    = state_q == YR || state_q == RY;
        red       = state_q == RR_A || state_q == RR_B;
        t_end     = green ? G_END : yellow ? Y_END : red ? R_END : F_END;
        expire    = tick && timer_q == t_end;
        stop      = mode_q == 2'b01 || mode_q == 2'b10;
        state_d   = state_q;
        timer_d   = tick ? timer_q + TW'(1) : timer_q;
        blink_d   = blink_q;
        if (state_q == FLASH) begin
            if (mode_q != 2'b01) begin
                state_d = RR_A;
            end else if (expire) begin
                timer_d = '0;
                blink_d = ~blink_q;
            end
        end else if (state_q > FLASH) begin
            state_d = RR_A;
        end else if (mode_q == 2'b11) begin
            timer_d = timer_q;
        end else if (stop && green) begin
            state_d = state_q + 3'd1;
        end else if (stop && red && expire) begin
            state_d = mode_q == 2'b01 ? FLASH : state_q;
            timer_d = timer_q;
        end else if (expire) begin
            state_d = state_q == RY ? RR_A : state_q + 3'd1;
        end
        // every state change restarts the phase timer and starts FLASH dark
        if (state_d != state_q) begin
            timer_d = '0;
            blink_d = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_meta_q <= 2'b00;
            mode_q    <= 2'b00;
            div_q     <= '0;
            timer_q   <= '0;
            state_q   <= RR_A;
            blink_q   <= 1'b0;
        end else begin
            sw_meta_q <= sw_meta_d;
            mode_q    <= mode_d;
            div_q     <= div_d;
            timer_q   <= timer_d;
            state_q   <= state_d;
            blink_q   <= blink_d;
        end
    end
    assign lit    = state_q == FLASH && blink_q;
    assign led4_r = red || state_q == YR || state_q == RG || state_q == RY || lit;
    assign led4_g = state_q == GR || state_q == YR || lit;
    assign led4_b = 1'b0;
    assign led5_r = red || state_q == GR || state_q == YR || state_q == RY || lit;
    assign led5_g = state_q == RG || state_q == RY || lit;
    assign led5_b = 1'b0;
    assign phase  = state_q;
endmodule

// File: tb/tb_traffic_light_ctrl_param.sv
// tb_traffic_light_ctrl_param: scoreboard bench with directed per-cycle phase/lamp expectations
module tb_traffic_light_ctrl_param;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] sw  = 2'b00;
    logic       s4r, s4g, s4b, s5r, s5g, s5b, f4r, f4g, f4b, f5r, f5g, f5b;
    logic [2:0] s_ph, f_ph;
    logic [5:0] s_leds, f_leds;
    typedef struct {
        int         cyc;
        int         scn;
        logic [2:0] ph;
        logic       bl;
    } exp_t;
    exp_t q_s[$];
    exp_t q_f[$];
    exp_t e;
    int   cyc, checks, errors, scn;

    always #5 clk = ~clk;

    traffic_light_ctrl_param u_slow (
        .clk(clk), .rst(rst), .sw(sw),
        .led4_r(s4r), .led4_g(s4g), .led4_b(s4b),
        .led5_r(s5r), .led5_g(s5g), .led5_b(s5b),
        .phase(s_ph)
    );

    traffic_light_ctrl_param #(.CLK_DIV(1)) u_fast (
        .clk(clk), .rst(rst), .sw(sw),
        .led4_r(f4r), .led4_g(f4g), .led4_b(f4b),
        .led5_r(f5r), .led5_g(f5g), .led5_b(f5b),
        .phase(f_ph)
    );

    assign s_leds = {s4r, s4g, s4b, s5r, s5g, s5b};
    assign f_leds = {f4r, f4g, f4b, f5r, f5g, f5b};

    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else cyc <= cyc + 1;
    end

    function automatic logic [5:0] lamps(input logic [2:0] ph, input logic bl);
        case (ph)
            3'd0: lamps = 6'b100_100;
            3'd1: lamps = 6'b010_100;
            3'd2: lamps = 6'b110_100;
            3'd3: lamps = 6'b100_100;
            3'd4: lamps = 6'b100_010;
            3'd5: lamps = 6'b100_110;
            3'd6: lamps = bl ? 6'b110_110 : 6'b000_000;
            default: lamps = 6'b000_000;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got phase=%0d leds=%b, expected phase=%0d leds=%b",
                     nm, act[8:6], act[5:0], want[8:6], want[5:0]);
        end
    endtask

    task automatic cmp(input string tag, input exp_t x, input logic [8:0] act);
        if (x.cyc != cyc) begin
            checks++;
            errors++;
            $display("FAIL %s s%0d missed: entry for cycle %0d seen at cycle %0d", tag, x.scn, x.cyc, cyc);
        end else begin
            chk($sformatf("%s s%0d c%0d", tag, x.scn, x.cyc), act, {x.ph, lamps(x.ph, x.bl)});
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            while (q_s.size() != 0 && q_s[0].cyc <= cyc) begin
                e = q_s.pop_front();
                cmp("slow", e, {s_ph, s_leds});
            end
            while (q_f.size() != 0 && q_f[0].cyc <= cyc) begin
                e = q_f.pop_front();
                cmp("fast", e, {f_ph, f_leds});
            end
        end
    end

    task automatic push(input bit fast, input int a, input int b, input logic [2:0] ph, input logic bl);
        for (int c = a; c <= b; c++) begin
            if (fast) q_f.push_back('{c, scn, ph, bl});
            else q_s.push_back('{c, scn, ph, bl});
        end
    endtask

    task automatic wait_cyc(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic release_rst();
        @(posedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic hold_rst();
        @(posedge clk);
        #2 rst = 1'b0;
        sw = 2'b00;
        repeat (2) @(posedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 500 && (q_s.size() != 0 || q_f.size() != 0); i++) @(negedge clk);
        #1;
        if (q_s.size() != 0 || q_f.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain s%0d: %0d entries left, required 0", scn, q_s.size() + q_f.size());
            q_s.delete();
            q_f.delete();
        end
    endtask

    initial begin
        // normal sequence on both prescaler settings
        scn = 1;
        push(0, 0, 3, 3'd0, 0);   push(0, 4, 23, 3'd1, 0);  push(0, 24, 31, 3'd2, 0);
        push(0, 32, 35, 3'd3, 0); push(0, 36, 55, 3'd4, 0); push(0, 56, 63, 3'd5, 0);
        push(0, 64, 67, 3'd0, 0);
        push(1, 0, 0, 3'd0, 0);   push(1, 1, 5, 3'd1, 0);   push(1, 6, 7, 3'd2, 0);
        push(1, 8, 8, 3'd3, 0);   push(1, 9, 13, 3'd4, 0);  push(1, 14, 15, 3'd5, 0);
        push(1, 16, 16, 3'd0, 0); push(1, 17, 17, 3'd1, 0);
        release_rst();
        drain();
        // night flash entered from GR, then back to normal
        hold_rst();
        scn = 2;
        push(0, 0, 3, 3'd0, 0);   push(0, 4, 12, 3'd1, 0);  push(0, 13, 19, 3'd2, 0);
        push(0, 20, 23, 3'd3, 0); push(0, 24, 27, 3'd6, 0); push(0, 28, 31, 3'd6, 1);
        push(0, 32, 35, 3'd6, 0); push(0, 36, 39, 3'd6, 1); push(0, 40, 43, 3'd6, 0);
        push(0, 44, 46, 3'd6, 1); push(0, 47, 47, 3'd0, 0); push(0, 48, 67, 3'd1, 0);
        push(0, 68, 70, 3'd2, 0);
        release_rst();
        wait_cyc(10);
        sw = 2'b01;
        wait_cyc(44);
        sw = 2'b00;
        drain();
        // all-red entered from RG, held, then released
        hold_rst();
        scn = 3;
        push(0, 0, 3, 3'd0, 0);   push(0, 4, 23, 3'd1, 0);  push(0, 24, 31, 3'd2, 0);
        push(0, 32, 35, 3'd3, 0); push(0, 36, 42, 3'd4, 0); push(0, 43, 47, 3'd5, 0);
        push(0, 48, 83, 3'd0, 0); push(0, 84, 90, 3'd1, 0);
        release_rst();
        wait_cyc(40);
        sw = 2'b10;
        wait_cyc(80);
        sw = 2'b00;
        drain();
        // freeze in YR with one tick remaining, then async reset in RG
        hold_rst();
        scn = 4;
        push(0, 0, 3, 3'd0, 0);   push(0, 4, 23, 3'd1, 0);  push(0, 24, 131, 3'd2, 0);
        push(0, 132, 135, 3'd3, 0); push(0, 136, 139, 3'd4, 0);
        release_rst();
        wait_cyc(26);
        sw = 2'b11;
        wait_cyc(128);
        sw = 2'b00;
        wait_cyc(140);
        #2 rst = 1'b0;
        #1;
        chk("async reset slow", {s_ph, s_leds}, {3'd0, 6'b100_100});
        chk("async reset fast", {f_ph, f_leds}, {3'd0, 6'b100_100});
        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
